stack_controller: RTL and testbench

Multi-cycle control FSM for the 8-bit stack-machine datapath. Consumes the 3-bit opcode from the instruction register and the top-of-stack value. Sequences fetch, decode and execute by driving every datapath control strobe (PC, IR, MDR, A/B loads, stack push/pop, memory, ALU op). Sits directly upstream of the datapath as its only source of control.

---
 rtl/stack_ctrl_pkg.sv | 60 ++++++
 rtl/stack_ctrl_outdec.sv | 91 +++++++++
 rtl/stack_controller.sv | 102 ++++++++++
 tb/tb_stack_controller.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/stack_ctrl_pkg.sv
// Shared types for the stack-machine controller: opcodes, ALU ops, FSM states
// and the packed control vector. STACK_GUARD_EN adds the fault flag to the vector.
package stack_ctrl_pkg;

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_SUB  = 3'b001,
        OP_AND  = 3'b010,
        OP_NOT  = 3'b011,
        OP_PUSH = 3'b100,
        OP_POP  = 3'b101,
        OP_JMP  = 3'b110,
        OP_JZ   = 3'b111
    } opcode_e;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_NOT = 2'b11
    } alu_op_e;

    typedef enum logic [3:0] {
        IDLE,
        FETCH,
        DECODE,
        POP_A,
        POP_B,
        ALU_WB,
        RD_MEM,
        PUSH_MDR,
        WR_MEM,
        JUMP,
        JZ_CHK,
        FAULT
    } ctrl_state_e;

    localparam logic [7:0] TOS_ZERO = 8'h00;

    typedef struct packed {
        logic    addr_src;
        logic    mem_read;
        logic    mem_write;
        logic    ir_write;
        logic    mdr_en;
        logic    pc_write;
        logic    jump;
        logic    load_a;
        logic    load_b;
        logic    push;
        logic    pop;
        logic    stack_src;
        alu_op_e alu_op;
        logic    instr_done;
`ifdef STACK_GUARD_EN
        logic    fault;
`endif
    } ctrl_vec_t;

endpackage

// File: rtl/stack_ctrl_outdec.sv
// Combinational state/opcode/tos to control-vector decoder.
// With STACK_GUARD_EN, stack accesses are suppressed on empty/full and a trip flag is raised.
module stack_ctrl_outdec
    import stack_ctrl_pkg::*;
(
    input  ctrl_state_e i_state,
    input  logic [1:0]  i_alu_sel,
    input  logic [7:0]  i_tos,
`ifdef STACK_GUARD_EN
    input  logic        i_stack_empty,
    input  logic        i_stack_full,
    output logic        o_guard_trip,
`endif
    output ctrl_vec_t   o_ctrl
);

    always_comb begin
        o_ctrl = '0;
`ifdef STACK_GUARD_EN
        o_guard_trip = 1'b0;
`endif
        case (i_state)
            FETCH: begin
                o_ctrl.mem_read = 1'b1;
                o_ctrl.ir_write = 1'b1;
                o_ctrl.pc_write = 1'b1;
            end
            POP_A: begin
                o_ctrl.load_a = 1'b1;
                o_ctrl.pop    = 1'b1;
            end
            POP_B: begin
                o_ctrl.load_b = 1'b1;
                o_ctrl.pop    = 1'b1;
            end
            ALU_WB: begin
                o_ctrl.push       = 1'b1;
                o_ctrl.alu_op     = alu_op_e'(i_alu_sel);
                o_ctrl.instr_done = 1'b1;
            end
            RD_MEM: begin
                o_ctrl.addr_src = 1'b1;
                o_ctrl.mem_read = 1'b1;
                o_ctrl.mdr_en   = 1'b1;
            end
            PUSH_MDR: begin
                o_ctrl.push       = 1'b1;
                o_ctrl.stack_src  = 1'b1;
                o_ctrl.instr_done = 1'b1;
            end
            WR_MEM: begin
                o_ctrl.addr_src   = 1'b1;
                o_ctrl.mem_write  = 1'b1;
                o_ctrl.pop        = 1'b1;
                o_ctrl.instr_done = 1'b1;
            end
            JUMP: begin
                o_ctrl.jump       = 1'b1;
                o_ctrl.pc_write   = 1'b1;
                o_ctrl.instr_done = 1'b1;
            end
            JZ_CHK: begin
                // jump stays high; pc_write alone decides whether the target is taken
                o_ctrl.jump       = 1'b1;
                o_ctrl.pc_write   = (i_tos == TOS_ZERO);
                o_ctrl.instr_done = 1'b1;
            end
`ifdef STACK_GUARD_EN
            FAULT: begin
                o_ctrl.fault = 1'b1;
            end
`endif
            default: o_ctrl = '0;
        endcase

`ifdef STACK_GUARD_EN
        if (i_stack_empty && (i_state == POP_A || i_state == POP_B || i_state == WR_MEM)) begin
            o_ctrl.pop       = 1'b0;
            o_ctrl.load_a    = 1'b0;
            o_ctrl.load_b    = 1'b0;
            o_ctrl.mem_write = 1'b0;
            o_guard_trip     = 1'b1;
        end
        if (i_stack_full && (i_state == ALU_WB || i_state == PUSH_MDR)) begin
            o_ctrl.push  = 1'b0;
            o_guard_trip = 1'b1;
        end
`endif
    end

endmodule

// File: rtl/stack_controller.sv
// Multi-cycle fetch/decode/execute FSM for the 8-bit stack machine.
// Define STACK_GUARD_EN to add stack over/underflow detection and a sticky FAULT state.
module stack_controller
    import stack_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] opcode,
    input  logic [7:0] tos,
`ifdef STACK_GUARD_EN
    input  logic       stack_empty,
    input  logic       stack_full,
    output logic       fault,
`endif
    output logic       addr_src,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mdr_en,
    output logic       pc_write,
    output logic       jump,
    output logic       load_a,
    output logic       load_b,
    output logic       push,
    output logic       pop,
    output logic       stack_src,
    output logic [1:0] alu_op,
    output logic       instr_done
);

    ctrl_state_e r_state;
    ctrl_state_e w_state_next;
    ctrl_vec_t   w_ctrl;
`ifdef STACK_GUARD_EN
    logic        w_guard_trip;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:   w_state_next = FETCH;
            FETCH:  w_state_next = DECODE;
            DECODE: begin
                case (opcode_e'(opcode))
                    OP_PUSH: w_state_next = RD_MEM;
                    OP_POP:  w_state_next = WR_MEM;
                    OP_JMP:  w_state_next = JUMP;
                    OP_JZ:   w_state_next = JZ_CHK;
                    default: w_state_next = POP_A;
                endcase
            end
            POP_A:    w_state_next = (opcode_e'(opcode) == OP_NOT) ? ALU_WB : POP_B;
            POP_B:    w_state_next = ALU_WB;
            RD_MEM:   w_state_next = PUSH_MDR;
            ALU_WB, PUSH_MDR, WR_MEM, JUMP, JZ_CHK:
                      w_state_next = FETCH;
`ifdef STACK_GUARD_EN
            FAULT:    w_state_next = FAULT;
`endif
            default:  w_state_next = IDLE;
        endcase
`ifdef STACK_GUARD_EN
        if (w_guard_trip) w_state_next = FAULT;
`endif
    end

    stack_ctrl_outdec u_outdec (
        .i_state       (r_state),
        .i_alu_sel     (opcode[1:0]),
        .i_tos         (tos),
`ifdef STACK_GUARD_EN
        .i_stack_empty (stack_empty),
        .i_stack_full  (stack_full),
        .o_guard_trip  (w_guard_trip),
`endif
        .o_ctrl        (w_ctrl)
    );

    assign addr_src   = w_ctrl.addr_src;
    assign mem_read   = w_ctrl.mem_read;
    assign mem_write  = w_ctrl.mem_write;
    assign ir_write   = w_ctrl.ir_write;
    assign mdr_en     = w_ctrl.mdr_en;
    assign pc_write   = w_ctrl.pc_write;
    assign jump       = w_ctrl.jump;
    assign load_a     = w_ctrl.load_a;
    assign load_b     = w_ctrl.load_b;
    assign push       = w_ctrl.push;
    assign pop        = w_ctrl.pop;
    assign stack_src  = w_ctrl.stack_src;
    assign alu_op     = w_ctrl.alu_op;
    assign instr_done = w_ctrl.instr_done;
`ifdef STACK_GUARD_EN
    assign fault      = w_ctrl.fault;
`endif

endmodule

// File: tb/tb_stack_controller.sv
// Self-checking bench for stack_controller: an instruction-level model expands each
// opcode into its expected per-cycle control vectors; covers STACK_GUARD_EN when defined.
module tb_stack_controller;

    typedef struct packed {
        logic       addr_src;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mdr_en;
        logic       pc_write;
        logic       jump;
        logic       load_a;
        logic       load_b;
        logic       push;
        logic       pop;
        logic       stack_src;
        logic [1:0] alu_op;
        logic       instr_done;
    } vec_t;

    localparam logic [2:0] C_ADD = 3'b000, C_SUB = 3'b001, C_AND = 3'b010, C_NOT = 3'b011;
    localparam logic [2:0] C_PUSH = 3'b100, C_POP = 3'b101, C_JMP = 3'b110, C_JZ = 3'b111;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [2:0] opcode = 3'b000;
    logic [7:0] tos = 8'h00;
    logic addr_src, mem_read, mem_write, ir_write, mdr_en, pc_write, jump;
    logic load_a, load_b, push, pop, stack_src, instr_done;
    logic [1:0] alu_op;
`ifdef STACK_GUARD_EN
    logic stack_empty = 1'b0;
    logic stack_full  = 1'b0;
    logic fault;
`endif

    int checks = 0;
    int failures = 0;
    vec_t exp_q[$];
    vec_t act;

    always #5 clk = ~clk;

    stack_controller dut (
        .clk        (clk),
        .rst        (rst),
        .opcode     (opcode),
        .tos        (tos),
`ifdef STACK_GUARD_EN
        .stack_empty(stack_empty),
        .stack_full (stack_full),
        .fault      (fault),
`endif
        .addr_src   (addr_src),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .ir_write   (ir_write),
        .mdr_en     (mdr_en),
        .pc_write   (pc_write),
        .jump       (jump),
        .load_a     (load_a),
        .load_b     (load_b),
        .push       (push),
        .pop        (pop),
        .stack_src  (stack_src),
        .alu_op     (alu_op),
        .instr_done (instr_done)
    );

    assign act = {addr_src, mem_read, mem_write, ir_write, mdr_en, pc_write, jump,
                  load_a, load_b, push, pop, stack_src, alu_op, instr_done};

    // Instruction-level model: appends the expected cycle sequence, FETCH first.
    function automatic void model(input logic [2:0] op, input logic [7:0] t);
        vec_t v;
        exp_q.delete();
        v = '0; v.mem_read = 1; v.ir_write = 1; v.pc_write = 1; exp_q.push_back(v);
        v = '0; exp_q.push_back(v);
        if (op <= C_NOT) begin
            v = '0; v.load_a = 1; v.pop = 1; exp_q.push_back(v);
            if (op != C_NOT) begin
                v = '0; v.load_b = 1; v.pop = 1; exp_q.push_back(v);
            end
            v = '0; v.push = 1; v.alu_op = op[1:0]; v.instr_done = 1; exp_q.push_back(v);
        end else if (op == C_PUSH) begin
            v = '0; v.addr_src = 1; v.mem_read = 1; v.mdr_en = 1; exp_q.push_back(v);
            v = '0; v.push = 1; v.stack_src = 1; v.instr_done = 1; exp_q.push_back(v);
        end else if (op == C_POP) begin
            v = '0; v.addr_src = 1; v.mem_write = 1; v.pop = 1; v.instr_done = 1; exp_q.push_back(v);
        end else begin
            v = '0; v.jump = 1; v.pc_write = (op == C_JMP) || (t == 8'h00); v.instr_done = 1;
            exp_q.push_back(v);
        end
    endfunction

    function automatic int cycles_for(input logic [2:0] op);
        case (op)
            C_ADD, C_SUB, C_AND: return 5;
            C_NOT, C_PUSH:       return 4;
            default:             return 3;
        endcase
    endfunction

    task automatic check_vec(input string nm, input vec_t exp, input logic exp_fault);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
`ifdef STACK_GUARD_EN
        checks++;
        if (fault !== exp_fault) begin
            failures++;
            $display("FAIL %s_fault: got %b expected %b", nm, fault, exp_fault);
        end
`else
        if (exp_fault) $display("note: fault expectation ignored without guard");
`endif
    endtask

    task automatic check_int(input string nm, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    // Drives one instruction and checks every cycle from FETCH to instr_done.
    task automatic run_instr(input logic [2:0] op, input logic [7:0] t, input string nm);
        int len = 0;
        opcode = op;
        tos    = t;
        model(op, t);
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge clk);
            check_vec($sformatf("%s_c%0d", nm, i), exp_q[i], 1'b0);
            if (instr_done === 1'b1 && len == 0) len = i + 1;
        end
        check_int({nm, "_cycles"}, len, cycles_for(op));
        $display("txn %s op=%b tos=%h cycles=%0d", nm, op, t, len);
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check_vec("post_reset_idle", '0, 1'b0);
    endtask

    initial begin
        vec_t zero_v;
        zero_v = '0;

        // Literal pins on the model itself
        model(C_ADD, 8'h00);
        check_int("model_add_len", exp_q.size(), 5);
        checks++;
        if (exp_q[2] !== 15'b000000010010000) begin
            failures++; $display("FAIL model_add_popa: got %b expected %b", exp_q[2], 15'b000000010010000);
        end
        model(C_NOT, 8'h00);
        checks++;
        if (exp_q[3] !== 15'b000000000100111) begin
            failures++; $display("FAIL model_not_wb: got %b expected %b", exp_q[3], 15'b000000000100111);
        end
        model(C_JZ, 8'h05);
        checks++;
        if (exp_q[2] !== 15'b000000100000001) begin
            failures++; $display("FAIL model_jz_nz: got %b expected %b", exp_q[2], 15'b000000100000001);
        end

        // Reset state and first fetch
        #12;
        check_vec("in_reset", zero_v, 1'b0);
        release_reset();

        run_instr(C_ADD,  8'h11, "add");
        run_instr(C_SUB,  8'h22, "sub");
        run_instr(C_AND,  8'h33, "and");
        run_instr(C_NOT,  8'h44, "not");
        run_instr(C_PUSH, 8'h55, "push");
        run_instr(C_POP,  8'h66, "pop");
        run_instr(C_JMP,  8'h77, "jmp");
        run_instr(C_JZ,   8'h00, "jz_zero");
        run_instr(C_JZ,   8'h05, "jz_nonzero");

        // Reset asserted mid-POP_B must clear outputs immediately
        opcode = C_ADD;
        model(C_ADD, 8'h00);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_vec($sformatf("rst_add_c%0d", i), exp_q[i], 1'b0);
        end
        #1 rst = 1'b0;
        #1 check_vec("rst_async_clear", zero_v, 1'b0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check_vec("rst_held", zero_v, 1'b0);
        end
        release_reset();
        $display("txn reset_mid_popb done");

        run_instr(C_PUSH, 8'h01, "push_after_rst");
        run_instr(C_JZ,   8'h00, "jz_after_rst");

`ifdef STACK_GUARD_EN
        // Underflow at POP_A: pops suppressed, FAULT sticky until reset
        opcode = C_ADD;
        stack_empty = 1'b1;
        model(C_ADD, 8'h00);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check_vec($sformatf("guard_c%0d", i), exp_q[i], 1'b0);
        end
        @(negedge clk);
        check_vec("guard_popa_blocked", zero_v, 1'b0);
        stack_empty = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_vec($sformatf("guard_fault_%0d", i), zero_v, 1'b1);
        end
        #1 rst = 1'b0;
        #1 check_vec("guard_fault_cleared", zero_v, 1'b0);
        release_reset();
        $display("txn guard_underflow done");
        run_instr(C_ADD, 8'h00, "add_after_fault");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog so the run always terminates
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
